csa_tree_pipe: RTL

Parametrised, pipelined multi-operand carry-save compressor for the multiplier datapath. It accepts NUM_IN operands of WIDTH bits per beat and reduces them through cascaded 3:2 levels, with a register after every level. The result is either a carry-save pair or, optionally, a final resolved sum. It supersedes the fixed 128-bit, three-input combinational 3:2 compressor by adding:
- variable operand count;
- pipelining;
- valid/ready flow control.

---
 rtl/csa_tree_pipe_if.sv | 24 ++
 rtl/csa_tree_pipe.sv | 131 +++++++++++++
 2 files changed

// File: rtl/csa_tree_pipe_if.sv
// rtl/csa_tree_pipe_if.sv - operand/result stream bundle for csa_tree_pipe
// The slave side is the compressor; the master side is whoever feeds and drains it.
interface csa_tree_pipe_if #(
    parameter int WIDTH  = 128,
    parameter int NUM_IN = 3
) ();
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        sum_o;
    logic [WIDTH-1:0]        carry_o;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, sum_o, carry_o
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, sum_o, carry_o
    );
endinterface

// File: rtl/csa_tree_pipe.sv
// rtl/csa_tree_pipe.sv - pipelined multi-operand carry-save compressor
// Cascaded 3:2 levels with a register after each, optional final carry-propagate stage.
module csa_tree_pipe #(
    parameter int WIDTH     = 128,
    parameter int NUM_IN    = 3,
    parameter int FINAL_ADD = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    csa_tree_pipe_if.slave bus
);
    function automatic int rows_after(input int n, input int lv);
        int r;
        r = n;
        for (int i = 0; i < lv; i++) r = (r / 3) * 2 + (r % 3);
        return r;
    endfunction

    function automatic int num_levels(input int n);
        int r;
        int l;
        r = n;
        l = 0;
        while (r > 2) begin
            r = (r / 3) * 2 + (r % 3);
            l++;
        end
        return l;
    endfunction

    localparam int LV = num_levels(NUM_IN);
    localparam int D  = LV + FINAL_ADD;

    if (NUM_IN < 3 || NUM_IN > 9 || WIDTH < 4 || WIDTH > 256 ||
        (FINAL_ADD != 0 && FINAL_ADD != 1)) begin : g_param_check
        $fatal(1, "csa_tree_pipe: illegal parameter combination");
    end

    logic [D-1:0] v_q;
    logic [D-1:0] v_d;
    logic [D-1:0] en;

    // A stage may advance if it is empty or everything downstream of it advances.
    always_comb begin
        logic rdy;
        rdy = bus.out_ready;
        en  = '0;
        for (int s = D - 1; s >= 0; s--) begin
            rdy   = ~v_q[s] | rdy;
            en[s] = rdy;
        end
    end

    always_comb begin
        v_d = v_q;
        if (en[0]) v_d[0] = bus.in_valid;
        for (int s = 1; s < D; s++) begin
            if (en[s]) v_d[s] = v_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) v_q <= '0;
        else        v_q <= v_d;
    end

    for (genvar s = 0; s < LV; s++) begin : g_lvl
        localparam int RI = rows_after(NUM_IN, s);
        localparam int RO = rows_after(NUM_IN, s + 1);
        localparam int NG = RI / 3;

        logic [RI*WIDTH-1:0] d_in;
        logic [RO*WIDTH-1:0] row_d;
        logic [RO*WIDTH-1:0] row_q;
        logic                vin;

        if (s == 0) begin : g_src
            assign d_in = bus.in_data;
            assign vin  = bus.in_valid;
        end else begin : g_src
            assign d_in = g_lvl[s-1].row_q;
            assign vin  = v_q[s-1];
        end

        // Groups of three rows become a sum/carry pair; one or two leftovers pass through.
        always_comb begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            logic [WIDTH-1:0] c;
            row_d = '0;
            a     = '0;
            b     = '0;
            c     = '0;
            for (int g = 0; g < NG; g++) begin
                a = d_in[(3*g)*WIDTH +: WIDTH];
                b = d_in[(3*g+1)*WIDTH +: WIDTH];
                c = d_in[(3*g+2)*WIDTH +: WIDTH];
                row_d[(2*g)*WIDTH +: WIDTH]   = a ^ b ^ c;
                row_d[(2*g+1)*WIDTH +: WIDTH] = ((a & b) | (a & c) | (b & c)) << 1;
            end
            for (int k = 0; k < RI - 3 * NG; k++) begin
                row_d[(2*NG+k)*WIDTH +: WIDTH] = d_in[(3*NG+k)*WIDTH +: WIDTH];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)              row_q <= '0;
            else if (en[s] && vin)   row_q <= row_d;
        end
    end

    if (FINAL_ADD != 0) begin : g_fin
        logic [WIDTH-1:0] tot_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                tot_q <= '0;
            else if (en[LV] && v_q[LV-1])
                tot_q <= g_lvl[LV-1].row_q[0 +: WIDTH] + g_lvl[LV-1].row_q[WIDTH +: WIDTH];
        end

        assign bus.sum_o   = tot_q;
        assign bus.carry_o = '0;
    end else begin : g_fin
        assign bus.sum_o   = g_lvl[LV-1].row_q[0 +: WIDTH];
        assign bus.carry_o = g_lvl[LV-1].row_q[WIDTH +: WIDTH];
    end

    assign bus.in_ready  = en[0];
    assign bus.out_valid = v_q[D-1];
endmodule
